// File: rtl/writeback_regfile_pkg.sv
// Shared constants for the write-back stage and register file.
// Optional retired-write counter is enabled with WB_RETIRE_CNT_EN.
`ifndef XLEN
`define XLEN 64
`endif

package writeback_regfile_pkg;

  localparam int WB_XLEN = `XLEN;
  localparam int WB_NREG = 32;
  localparam int REG_W   = 5;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/writeback_regfile_regfile_2r1w.sv
// Two-read one-write integer register array.
// x0 is hard-wired to zero; reset clears every entry.
module regfile_2r1w
    import writeback_regfile_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int NREG = WB_NREG
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [REG_W-1:0] waddr_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [REG_W-1:0] raddr1_i,
    input  logic [REG_W-1:0] raddr2_i,
    output logic [XLEN-1:0]  rdata1_o,
    output logic [XLEN-1:0]  rdata2_o
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we_i && waddr_i != ZERO_REG) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == ZERO_REG) ? '0 : regs[raddr1_i];
    assign rdata2_o = (raddr2_i == ZERO_REG) ? '0 : regs[raddr2_i];

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage: result select, register commit, decode bypass.
// Retired-write counter present only with WB_RETIRE_CNT_EN defined.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int NREG = WB_NREG
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             MD_sel_reg_i,
    input  logic [XLEN-1:0]  MD_valM_i,
    input  logic [XLEN-1:0]  MD_valE_i,
    input  logic             MD_need_dstE_i,
    input  logic [REG_W-1:0] MD_dstE_i,
    input  logic [REG_W-1:0] D_src1_i,
    input  logic [REG_W-1:0] D_src2_i,
    output logic [XLEN-1:0]  D_val1_o,
    output logic [XLEN-1:0]  D_val2_o,
    output logic             W_we_o,
    output logic [REG_W-1:0] W_dstE_o,
    output logic [XLEN-1:0]  W_valW_o,
    output logic [63:0]      W_retire_cnt_o
);

    logic [XLEN-1:0] val_w;
    logic [XLEN-1:0] arr1;
    logic [XLEN-1:0] arr2;
    logic            we;
    logic            byp1;
    logic            byp2;

    assign val_w = MD_sel_reg_i ? MD_valM_i : MD_valE_i;
    // Reset masks the write so a bundle in a reset cycle is dropped.
    assign we = MD_need_dstE_i & (MD_dstE_i != ZERO_REG) & ~rst_i;

    assign W_we_o   = we;
    assign W_dstE_o = MD_dstE_i;
    assign W_valW_o = val_w;

    regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (we),
        .waddr_i  (MD_dstE_i),
        .wdata_i  (val_w),
        .raddr1_i (D_src1_i),
        .raddr2_i (D_src2_i),
        .rdata1_o (arr1),
        .rdata2_o (arr2)
    );

    assign byp1 = we && (D_src1_i == MD_dstE_i);
    assign byp2 = we && (D_src2_i == MD_dstE_i);

    assign D_val1_o = (D_src1_i == ZERO_REG) ? '0 :
                      byp1 ? val_w : arr1;
    assign D_val2_o = (D_src2_i == ZERO_REG) ? '0 :
                      byp2 ? val_w : arr2;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retire_cnt <= '0;
        end else if (we) begin
            retire_cnt <= retire_cnt + 64'd1;
        end
    end

    assign W_retire_cnt_o = retire_cnt;
`else
    assign W_retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed plus random bench for writeback_regfile against an array model.
// Counter expectations follow WB_RETIRE_CNT_EN.
module tb_writeback_regfile;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [63:0] val_m;
    logic [63:0] val_e;
    logic        need;
    logic [4:0]  dst;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [63:0] val1;
    logic [63:0] val2;
    logic        w_we;
    logic [4:0]  w_dst;
    logic [63:0] w_val;
    logic [63:0] w_cnt;

    int n_cmp;
    int n_bad;

    logic [63:0]     model [32];
    longint unsigned m_cnt;

    writeback_regfile dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .MD_sel_reg_i   (sel),
        .MD_valM_i      (val_m),
        .MD_valE_i      (val_e),
        .MD_need_dstE_i (need),
        .MD_dstE_i      (dst),
        .D_src1_i       (src1),
        .D_src2_i       (src2),
        .D_val1_o       (val1),
        .D_val2_o       (val2),
        .W_we_o         (w_we),
        .W_dstE_o       (w_dst),
        .W_valW_o       (w_val),
        .W_retire_cnt_o (w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_cnt();
`ifdef WB_RETIRE_CNT_EN
        return m_cnt;
`else
        return 64'd0;
`endif
    endfunction

    function automatic logic [63:0] exp_rd(input logic [4:0] s,
                                           input logic wr,
                                           input logic [4:0] d,
                                           input logic [63:0] v);
        if (s == 0) return 64'd0;
        if (wr && s == d) return v;
        return model[s];
    endfunction

    // One cycle: drive, check combinational view, then commit to the model.
    task automatic step(input logic r, input logic s, input logic [63:0] vm,
                        input logic [63:0] ve, input logic n,
                        input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2);
        logic        ewe;
        logic [63:0] ev;
        rst = r; sel = s; val_m = vm; val_e = ve;
        need = n; dst = d; src1 = s1; src2 = s2;
        #2;
        ewe = n && (d != 0) && !r;
        ev  = s ? vm : ve;
        chk("we", {63'd0, w_we}, {63'd0, ewe});
        chk("dst", {59'd0, w_dst}, {59'd0, d});
        chk("valW", w_val, ev);
        chk("val1", val1, exp_rd(s1, ewe, d, ev));
        chk("val2", val2, exp_rd(s2, ewe, d, ev));
        chk("cnt", w_cnt, exp_cnt());
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 64'd0;
            m_cnt = 0;
        end else if (ewe) begin
            model[d] = ev;
            m_cnt++;
        end
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_cnt = 0;
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        rst = 1'b1; sel = 1'b0; val_m = '0; val_e = '0;
        need = 1'b0; dst = '0; src1 = '0; src2 = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++)
            step(1, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
        for (int i = 0; i < 32; i++)
            step(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));

        step(0, 0, 0, 64'h1234, 1, 5, 5, 5);
        step(0, 0, 0, 0, 0, 0, 5, 0);
        step(0, 1, 64'hDEADBEEF, 64'h1, 1, 7, 7, 5);
        step(0, 0, 0, 0, 0, 0, 7, 7);
        step(0, 0, 0, 64'hFF, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 7);
        step(1, 0, 0, 64'h55, 1, 3, 3, 7);
        step(0, 0, 0, 0, 0, 0, 3, 7);

        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 0, 64'(i * 17), 1, 5'(i), 5'(i), 5'(i - 1));
            if (i % 3 == 0) step(0, 0, 0, 0, 0, 0, 5'(i), 1);
            if (i == 5) step(0, 0, 0, 64'hAB, 1, 0, 0, 5);
        end
        step(0, 0, 0, 0, 0, 0, 10, 1);
`ifdef WB_RETIRE_CNT_EN
        chk("cnt10", w_cnt, 64'd10);
`else
        chk("cnt_off", w_cnt, 64'd0);
`endif

        for (int k = 0; k < 400; k++) begin
            logic [4:0] d;
            logic [4:0] a;
            logic [4:0] b;
            d = 5'($urandom_range(0, 31));
            a = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
            b = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
            step($urandom_range(0, 39) == 0, 1'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 3) != 0, d, a, b);
        end

        for (int i = 0; i < 32; i++)
            step(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
